// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional feature macro: BCD_BLANK_EN (leading-zero blank mask output).
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Enough decimal digits to hold 2**width-1 (log10(2) ~ 0.3).
    function automatic int bcd_digits(input int width);
        return (width * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between the converter and its producer/consumer.
// Optional feature macro: BCD_BLANK_EN adds blank_mask.
interface bin2bcd_seq_if #(
    parameter int WIDTH = 8
);
    import bcd_pkg::*;

    localparam int DIGITS = bcd_digits(WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  busy;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     blank_mask;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, busy, blank_mask
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, busy, blank_mask
    );
`else
    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, busy
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, busy
    );
`endif

endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= BCD_ADJ_THRESH) ? (d_i + BCD_ADJ_ADD) : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
// Optional feature macro: BCD_BLANK_EN (registered leading-zero blank mask).
//
// state | meaning
// IDLE  | ready for a new operand
// SHIFT | adjust + shift one bit per cycle, WIDTH cycles
// DONE  | result valid, held until out_ready
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int DIGITS = bcd_digits(WIDTH);
    localparam int BW     = 4 * DIGITS;
    localparam int CW     = $clog2(WIDTH);

    bcd_state_t        state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [BW-1:0]     acc_adj;
    logic [BW-1:0]     acc_sh;
    logic [WIDTH-1:0]  bin_sh;
    logic [BW-1:0]     out_bcd_q, out_bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_load;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[4*g +: 4]),
            .d_o (acc_adj[4*g +: 4])
        );
    end

    // The MSB of the adjusted accumulator falls off; DIGITS is sized so it is always 0.
    assign {acc_sh, bin_sh} = {acc_adj, bin_q} << 1;
    assign done_load        = (state_q == SHIFT) && (cnt_q == '0);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_bcd_q <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_bcd_q <= out_bcd_d;
        end
    end

    // Next-state and datapath update; out_bcd only changes on entry to DONE.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_bcd_d = out_bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bin_d   = bus.in_bin;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = bin_sh;
                acc_d = acc_sh;
                if (cnt_q == '0) begin
                    out_bcd_d = acc_sh;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == SHIFT);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_bcd   = out_bcd_q;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              hi_zero;

    // A digit is blank when it and every digit above it are zero; units never blank.
    always_comb begin
        blank_d = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero    = hi_zero & (acc_sh[4*i +: 4] == 4'd0);
            blank_d[i] = hi_zero;
        end
    end

    // Captured together with out_bcd so both follow the same valid window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (done_load) begin
            blank_q <= blank_d;
        end
    end

    assign bus.blank_mask = blank_q;
`endif

endmodule
